// File: rtl/toggle_req_debounce_pkg.sv
// Shared types and constants for the push-button front end: debounce FSM
// state encoding, edge-select codes and small elaboration helpers.
package toggle_req_debounce_pkg;

    // Debounce FSM states. Qualifying states sit between the two stable levels.
    typedef enum logic [1:0] {
        StStableLo = 2'b00,
        StQualHi   = 2'b01,
        StStableHi = 2'b10,
        StQualLo   = 2'b11
    } deb_state_e;

    // Edge-select codes for which accepted level change raises a toggle request.
    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_BOTH = 2;

    // True when an accepted change to new_level should produce a request.
    function automatic logic edge_selected(input int unsigned edge_sel, input logic new_level);
        return (edge_sel == EDGE_BOTH) ||
               ((edge_sel == EDGE_RISE) && new_level) ||
               ((edge_sel == EDGE_FALL) && !new_level);
    endfunction

    // Qualification counter width; never below one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/toggle_req_debounce_if.sv
// Button-side bundle between the stimulus (raw button, enable) and the
// debouncer's request/status outputs.
interface toggle_req_debounce_if #(
    parameter int unsigned CNT_W = 8
);
    logic             btn_in;
    logic             en;
    logic             t_pulse;
    logic             btn_level;
    logic             busy;
    logic [CNT_W-1:0] press_cnt;

    // Drives the raw button and enable, observes the request and status.
    modport master (
        output btn_in,
        output en,
        input  t_pulse,
        input  btn_level,
        input  busy,
        input  press_cnt
    );

    // The debouncer itself.
    modport slave (
        input  btn_in,
        input  en,
        output t_pulse,
        output btn_level,
        output busy,
        output press_cnt
    );
endinterface

// File: rtl/toggle_req_debounce_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; only the second
// stage is meant to be used by downstream logic.
module toggle_req_debounce_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic s1_q;
    logic s2_q;

    // Shift the raw input through two stages, both cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/toggle_req_debounce.sv
// Push-button front end for the toggle flop: synchronises a bouncy button,
// accepts a new level only after DEBOUNCE_CYCLES consecutive disagreeing
// samples, and turns selected accepted edges into a registered one-cycle
// toggle request. Also counts the requests issued (wrapping).
module toggle_req_debounce
    import toggle_req_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned EDGE_SEL        = 0,
    parameter int unsigned CNT_W           = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    toggle_req_debounce_if.slave bus
);
    localparam int unsigned     CntW    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    logic             btn_sync;
    deb_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic             accept;
    logic             busy;

    toggle_req_debounce_sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.btn_in),
        .q   (btn_sync)
    );

    // State, qualification counter, level, request and request count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StStableLo;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            pulse_q     <= 1'b0;
            press_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            pulse_q     <= pulse_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    // Next-state: start, continue, abort or accept a candidate level change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        accept  = 1'b0;
        unique case (state_q)
            StStableLo: begin
                if (btn_sync) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        // Single-sample qualification: accept on the first mismatch.
                        accept  = 1'b1;
                        state_d = StStableHi;
                        level_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = StQualHi;
                        cnt_d   = CntOne;
                    end
                end
            end
            StQualHi: begin
                if (!btn_sync) begin
                    state_d = StStableLo;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    accept  = 1'b1;
                    state_d = StStableHi;
                    level_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StStableHi: begin
                if (!btn_sync) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        accept  = 1'b1;
                        state_d = StStableLo;
                        level_d = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        state_d = StQualLo;
                        cnt_d   = CntOne;
                    end
                end
            end
            StQualLo: begin
                if (btn_sync) begin
                    state_d = StStableHi;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    accept  = 1'b1;
                    state_d = StStableLo;
                    level_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
        endcase
    end

    // Request and count: en only matters on the accepting edge.
    always_comb begin
        pulse_d     = accept && bus.en && edge_selected(EDGE_SEL, level_d);
        press_cnt_d = press_cnt_q + CNT_W'(pulse_d);
    end

    // Outputs decoded from registered state.
    always_comb begin
        busy = 1'b0;
        unique case (state_q)
            StQualHi, StQualLo:     busy = 1'b1;
            StStableLo, StStableHi: busy = 1'b0;
        endcase
    end

    assign bus.t_pulse   = pulse_q;
    assign bus.btn_level = level_q;
    assign bus.busy      = busy;
    assign bus.press_cnt = press_cnt_q;

endmodule

// File: tb/tb_toggle_req_debounce.sv
// Bench for toggle_req_debounce: three instances (press, release, both edges)
// share one button, checked each cycle against a run-length reference model,
// plus scenario-level expectations on counts, timing and the toggle flop.
module tb_toggle_req_debounce;
    localparam int unsigned Deb = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b0;
    logic en  = 1'b1;

    always #5 clk = ~clk;

    toggle_req_debounce_if #(.CNT_W(8)) bus0 ();
    toggle_req_debounce_if #(.CNT_W(8)) bus1 ();
    toggle_req_debounce_if #(.CNT_W(8)) bus2 ();

    assign bus0.btn_in = btn;
    assign bus1.btn_in = btn;
    assign bus2.btn_in = btn;
    assign bus0.en     = en;
    assign bus1.en     = en;
    assign bus2.en     = en;

    toggle_req_debounce #(.DEBOUNCE_CYCLES(Deb), .EDGE_SEL(0), .CNT_W(8)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );
    toggle_req_debounce #(.DEBOUNCE_CYCLES(Deb), .EDGE_SEL(1), .CNT_W(8)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );
    toggle_req_debounce #(.DEBOUNCE_CYCLES(Deb), .EDGE_SEL(2), .CNT_W(8)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // Toggle flops fed by each request; never reset.
    logic tq0 = 1'b0;
    logic tq1 = 1'b0;
    logic tq2 = 1'b0;
    always @(posedge clk) begin
        tq0 <= tq0 ^ bus0.t_pulse;
        tq1 <= tq1 ^ bus1.t_pulse;
        tq2 <= tq2 ^ bus2.t_pulse;
    end

    int d_pulse[3];
    int d_level[3];
    int d_busy[3];
    int d_cnt[3];
    int d_q[3];
    always_comb begin
        d_pulse[0] = int'(bus0.t_pulse);
        d_pulse[1] = int'(bus1.t_pulse);
        d_pulse[2] = int'(bus2.t_pulse);
        d_level[0] = int'(bus0.btn_level);
        d_level[1] = int'(bus1.btn_level);
        d_level[2] = int'(bus2.btn_level);
        d_busy[0]  = int'(bus0.busy);
        d_busy[1]  = int'(bus1.busy);
        d_busy[2]  = int'(bus2.busy);
        d_cnt[0]   = int'(bus0.press_cnt);
        d_cnt[1]   = int'(bus1.press_cnt);
        d_cnt[2]   = int'(bus2.press_cnt);
        d_q[0]     = int'(tq0);
        d_q[1]     = int'(tq1);
        d_q[2]     = int'(tq2);
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a 2-sample delay line, then a run of consecutive
    // samples disagreeing with the accepted level; a run of Deb accepts.
    int m_s1 = 0, m_s2 = 0;
    int m_level[3], m_run[3], m_pulse[3], m_cnt[3], m_q[3];
    int edge_no = 0;
    int first_busy0 = -1;
    int last_pulse0 = -1;

    function automatic bit wants(input int sel, input int lvl);
        return (sel == 2) || (sel == 0 && lvl == 1) || (sel == 1 && lvl == 0);
    endfunction

    task automatic model_edge(input logic r, input logic b, input logic e);
        for (int k = 0; k < 3; k++) m_q[k] ^= m_pulse[k];
        if (r) begin
            m_s1 = 0;
            m_s2 = 0;
            for (int k = 0; k < 3; k++) begin
                m_level[k] = 0; m_run[k] = 0; m_pulse[k] = 0; m_cnt[k] = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                m_pulse[k] = 0;
                if (m_s2 != m_level[k]) begin
                    m_run[k]++;
                    if (m_run[k] == Deb) begin
                        m_level[k] = m_s2;
                        m_run[k]   = 0;
                        if (e && wants(k, m_level[k])) begin
                            m_pulse[k] = 1;
                            m_cnt[k]   = (m_cnt[k] + 1) % 256;
                        end
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = int'(b);
        end
    endtask

    task automatic step(input logic r, input logic b, input logic e);
        rst = r;
        btn = b;
        en  = e;
        @(posedge clk);
        model_edge(r, b, e);
        #1;
        edge_no++;
        if (bus0.busy && first_busy0 < 0) first_busy0 = edge_no;
        if (bus0.t_pulse) last_pulse0 = edge_no;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("pulse%0d@%0d", k, edge_no), d_pulse[k], m_pulse[k]);
            check_eq($sformatf("level%0d@%0d", k, edge_no), d_level[k], m_level[k]);
            check_eq($sformatf("busy%0d@%0d", k, edge_no), d_busy[k], int'(m_run[k] > 0));
            check_eq($sformatf("cnt%0d@%0d", k, edge_no), d_cnt[k], m_cnt[k]);
            check_eq($sformatf("tff%0d@%0d", k, edge_no), d_q[k], m_q[k]);
        end
    endtask

    task automatic hold(input logic b, input logic e, input int n);
        for (int i = 0; i < n; i++) step(1'b0, b, e);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
        edge_no     = 0;
        first_busy0 = -1;
        last_pulse0 = -1;
    endtask

    int q0_start, q2_start;
    logic rb;
    int seg;

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_level[k] = 0; m_run[k] = 0; m_pulse[k] = 0; m_cnt[k] = 0; m_q[k] = 0;
        end
        #1;

        // 1: reset then idle.
        do_reset();
        hold(1'b0, 1'b1, 10);
        check_eq("idle_cnt0", d_cnt[0], 0);
        check_eq("idle_level0", d_level[0], 0);
        check_eq("idle_q0", d_q[0], 0);
        check_eq("idle_busy_seen", first_busy0, -1);

        // 2: clean press, then clean release.
        do_reset();
        hold(1'b1, 1'b1, 12);
        check_eq("press_busy_edge", first_busy0, 3);
        check_eq("press_pulse_edge", last_pulse0, Deb + 2);
        check_eq("press_level0", d_level[0], 1);
        check_eq("press_cnt0", d_cnt[0], 1);
        check_eq("press_cnt1", d_cnt[1], 0);
        check_eq("press_q0", d_q[0], 1);
        hold(1'b0, 1'b1, 12);
        check_eq("rel_cnt0", d_cnt[0], 1);
        check_eq("rel_cnt1", d_cnt[1], 1);
        check_eq("rel_cnt2", d_cnt[2], 2);

        // 3: bounce before settling high.
        do_reset();
        hold(1'b1, 1'b1, 2);
        hold(1'b0, 1'b1, 1);
        hold(1'b1, 1'b1, 8);
        check_eq("bounce_cnt0", d_cnt[0], 1);
        check_eq("bounce_pulse_edge", last_pulse0, 3 + Deb + 2);

        // 4: press 10 then release 10.
        do_reset();
        hold(1'b1, 1'b1, 10);
        hold(1'b0, 1'b1, 10);
        check_eq("both_cnt2", d_cnt[2], 2);
        check_eq("fall_cnt1", d_cnt[1], 1);
        check_eq("rise_cnt0", d_cnt[0], 1);

        // 5a: enable low during a full press/release.
        do_reset();
        hold(1'b1, 1'b0, 10);
        check_eq("dis_level0", d_level[0], 1);
        hold(1'b0, 1'b0, 10);
        check_eq("dis_cnt0", d_cnt[0], 0);
        check_eq("dis_cnt2", d_cnt[2], 0);

        // 5b: reset at edge 4 of a qualification.
        do_reset();
        hold(1'b1, 1'b1, 3);
        step(1'b1, 1'b1, 1'b1);
        check_eq("rstq_busy0", d_busy[0], 0);
        check_eq("rstq_level0", d_level[0], 0);
        hold(1'b0, 1'b1, 10);
        check_eq("rstq_cnt0", d_cnt[0], 0);

        // 5c: button held across reset still qualifies as a press afterwards.
        do_reset();
        step(1'b1, 1'b1, 1'b1);
        hold(1'b1, 1'b1, 8);
        check_eq("held_cnt0", d_cnt[0], 1);
        hold(1'b0, 1'b1, 8);

        // Randomised bouncy button, random enable, rare resets.
        for (int n = 0; n < 300; n++) begin
            rb  = 1'($urandom_range(0, 1));
            seg = int'($urandom_range(1, 9));
            for (int i = 0; i < seg; i++)
                step(1'($urandom_range(0, 199) == 0), rb, 1'($urandom_range(0, 3) != 0));
        end

        // 6: 256 clean presses wrap the counter back to zero.
        do_reset();
        q0_start = d_q[0];
        q2_start = d_q[2];
        for (int p = 0; p < 256; p++) begin
            hold(1'b1, 1'b1, 7);
            hold(1'b0, 1'b1, 7);
            if (p == 254) check_eq("wrap_cnt0_255", d_cnt[0], 255);
        end
        check_eq("wrap_cnt0", d_cnt[0], 0);
        check_eq("wrap_cnt1", d_cnt[1], 0);
        check_eq("wrap_cnt2", d_cnt[2], 0);
        check_eq("wrap_q0", d_q[0], q0_start);
        check_eq("wrap_q2", d_q[2], q2_start);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
